cc_random_row_selector: RTL and testbench

//  N-channel obstacle-row selector, next generation of the 4-way random-row mux.
//  - Channel 0 is the empty ("NADA") row. Channels 1..N-1 are candidate obstacle rows.
//  - On each load request it registers one row for the game matrix shifter.
//  - Manual mode: the row comes from an external select.
//  - Auto mode: a fixed number of empty gap rows, then one LFSR-picked obstacle row.

---
 rtl/cc_random_row_selector.sv | 87 ++++++++
 tb/tb_cc_random_row_selector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cc_random_row_selector.sv
// N-channel obstacle-row selector: registers one row per accepted load, either from a
// manual channel select or from an auto gap/LFSR-pick sequence.
module cc_random_row_selector #(
    parameter int unsigned DATAWIDTH   = 8,
    parameter int unsigned NUMCHANNELS = 4,
    parameter int unsigned SELECTWIDTH = 2,
    parameter int unsigned GAPROWS     = 2,
    parameter logic [7:0]  LFSRSEED    = 8'hA5
) (
    input  logic                             CC_RANDSEL_CLOCK_50,
    input  logic                             CC_RANDSEL_RESET_InLow,
    input  logic                             CC_RANDSEL_mode_In,
    input  logic                             CC_RANDSEL_pause_In,
    input  logic                             CC_RANDSEL_load_In,
    input  logic [SELECTWIDTH-1:0]           CC_RANDSEL_select_InBUS,
    input  logic [NUMCHANNELS*DATAWIDTH-1:0] CC_RANDSEL_channels_InBUS,
    output logic [DATAWIDTH-1:0]             CC_RANDSEL_row_OutBUS,
    output logic                             CC_RANDSEL_rowValid_Out,
    output logic [SELECTWIDTH-1:0]           CC_RANDSEL_index_OutBUS
);

    localparam int unsigned LFSRWIDTH = 8;
    localparam int unsigned GAPWIDTH  = 8;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSRWIDTH-1:0] SEEDVALUE = (LFSRSEED == 8'h00) ? 8'h01 : LFSRSEED;

    logic [LFSRWIDTH-1:0]   lfsr, lfsrNext;
    logic [GAPWIDTH-1:0]    gapCnt, gapCntNext;
    logic [DATAWIDTH-1:0]   rowNext;
    logic [SELECTWIDTH-1:0] indexNext;
    logic [SELECTWIDTH-1:0] pickIdx;
    logic [SELECTWIDTH-1:0] cand;
    logic                   validNext;
    logic                   accept;
    logic                   feedback;

    assign accept   = CC_RANDSEL_load_In && !CC_RANDSEL_pause_In;
    assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Next-state: gap countdown doubles as the GAP/PICK state in auto mode.
    always_comb begin
        lfsrNext   = lfsr;
        gapCntNext = gapCnt;
        rowNext    = CC_RANDSEL_row_OutBUS;
        indexNext  = CC_RANDSEL_index_OutBUS;
        validNext  = 1'b0;
        pickIdx    = '0;
        cand       = lfsr[SELECTWIDTH-1:0];
        if (accept) begin
            validNext = 1'b1;
            if (!CC_RANDSEL_mode_In) begin
                if (32'(CC_RANDSEL_select_InBUS) < NUMCHANNELS) begin
                    pickIdx = CC_RANDSEL_select_InBUS;
                end
            end else if (gapCnt != '0) begin
                gapCntNext = gapCnt - GAPWIDTH'(1);
            end else begin
                if (cand == '0 || 32'(cand) >= NUMCHANNELS) begin
                    cand = SELECTWIDTH'(1);
                end
                pickIdx    = cand;
                gapCntNext = GAPWIDTH'(GAPROWS);
                lfsrNext   = {lfsr[6:0], feedback};
            end
            indexNext = pickIdx;
            rowNext   = CC_RANDSEL_channels_InBUS[32'(pickIdx)*DATAWIDTH +: DATAWIDTH];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CC_RANDSEL_CLOCK_50) begin
        if (!CC_RANDSEL_RESET_InLow) begin
            lfsr                    <= SEEDVALUE;
            gapCnt                  <= GAPWIDTH'(GAPROWS);
            CC_RANDSEL_row_OutBUS   <= '0;
            CC_RANDSEL_rowValid_Out <= 1'b0;
            CC_RANDSEL_index_OutBUS <= '0;
        end else begin
            lfsr                    <= lfsrNext;
            gapCnt                  <= gapCntNext;
            CC_RANDSEL_row_OutBUS   <= rowNext;
            CC_RANDSEL_rowValid_Out <= validNext;
            CC_RANDSEL_index_OutBUS <= indexNext;
        end
    end

endmodule

// File: tb/tb_cc_random_row_selector.sv
// Directed bench for cc_random_row_selector: default, 3-channel and zero-gap instances.
module tb_cc_random_row_selector;

    logic       clk = 1'b0;
    logic       rstN;
    logic       mode;
    logic       pause;
    logic       load;
    logic [1:0] select;
    logic [31:0] chans4 = {8'h81, 8'h3C, 8'h18, 8'h00};
    logic [23:0] chans3 = {8'h3C, 8'h18, 8'h00};

    logic [7:0] rowA, rowB, rowC;
    logic       validA, validB, validC;
    logic [1:0] idxA, idxB, idxC;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    cc_random_row_selector dutA (
        .CC_RANDSEL_CLOCK_50(clk), .CC_RANDSEL_RESET_InLow(rstN),
        .CC_RANDSEL_mode_In(mode), .CC_RANDSEL_pause_In(pause),
        .CC_RANDSEL_load_In(load), .CC_RANDSEL_select_InBUS(select),
        .CC_RANDSEL_channels_InBUS(chans4), .CC_RANDSEL_row_OutBUS(rowA),
        .CC_RANDSEL_rowValid_Out(validA), .CC_RANDSEL_index_OutBUS(idxA)
    );

    cc_random_row_selector #(.NUMCHANNELS(3)) dutB (
        .CC_RANDSEL_CLOCK_50(clk), .CC_RANDSEL_RESET_InLow(rstN),
        .CC_RANDSEL_mode_In(mode), .CC_RANDSEL_pause_In(pause),
        .CC_RANDSEL_load_In(load), .CC_RANDSEL_select_InBUS(select),
        .CC_RANDSEL_channels_InBUS(chans3), .CC_RANDSEL_row_OutBUS(rowB),
        .CC_RANDSEL_rowValid_Out(validB), .CC_RANDSEL_index_OutBUS(idxB)
    );

    cc_random_row_selector #(.GAPROWS(0)) dutC (
        .CC_RANDSEL_CLOCK_50(clk), .CC_RANDSEL_RESET_InLow(rstN),
        .CC_RANDSEL_mode_In(mode), .CC_RANDSEL_pause_In(pause),
        .CC_RANDSEL_load_In(load), .CC_RANDSEL_select_InBUS(select),
        .CC_RANDSEL_channels_InBUS(chans4), .CC_RANDSEL_row_OutBUS(rowC),
        .CC_RANDSEL_rowValid_Out(validC), .CC_RANDSEL_index_OutBUS(idxC)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives load for one active edge, then samples 1 time unit after that edge.
    task automatic stepLoad(input logic ld);
        load = ld;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    logic [7:0] expRowsA [9] = '{8'h00, 8'h00, 8'h18, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h18};
    logic [1:0] expIdxA  [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [7:0] expRowsC [3] = '{8'h18, 8'h3C, 8'h18};
    logic [1:0] expIdxC  [3] = '{2'd1, 2'd2, 2'd1};
    logic [7:0] expRows4 [4] = '{8'h00, 8'h00, 8'h18, 8'h00};

    initial begin
        rstN = 1'b0; mode = 1'b0; pause = 1'b0; load = 1'b0; select = 2'd0;
        stepLoad(1'b1);
        checkVal("rst_row", 32'(rowA), 32'h00);
        checkVal("rst_valid", 32'(validA), 32'h0);
        checkVal("rst_index", 32'(idxA), 32'h0);
        checkVal("rst_lfsr", 32'(dutA.lfsr), 32'hA5);
        checkVal("rst_gap", 32'(dutA.gapCnt), 32'h2);
        rstN = 1'b1;

        // Manual select of channel 2, then a cycle with no load.
        select = 2'd2;
        stepLoad(1'b1);
        checkVal("man_row", 32'(rowA), 32'h3C);
        checkVal("man_index", 32'(idxA), 32'h2);
        checkVal("man_valid", 32'(validA), 32'h1);
        stepLoad(1'b0);
        checkVal("man_valid_drop", 32'(validA), 32'h0);
        checkVal("man_row_hold", 32'(rowA), 32'h3C);

        // Out-of-range select on the 3-channel instance falls back to channel 0.
        select = 2'd3;
        stepLoad(1'b1);
        checkVal("oor_row", 32'(rowB), 32'h00);
        checkVal("oor_index", 32'(idxB), 32'h0);
        checkVal("oor_lfsr", 32'(dutB.lfsr), 32'hA5);
        checkVal("sel3_row", 32'(rowA), 32'h81);
        checkVal("sel3_index", 32'(idxA), 32'h3);
        checkVal("man_gap_kept", 32'(dutA.gapCnt), 32'h2);

        rstN = 1'b0;
        stepLoad(1'b0);
        rstN = 1'b1;

        // Auto mode, back-to-back loads; the zero-gap instance picks on every load.
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            stepLoad(1'b1);
            checkVal($sformatf("auto_row%0d", i), 32'(rowA), 32'(expRowsA[i]));
            checkVal($sformatf("auto_idx%0d", i), 32'(idxA), 32'(expIdxA[i]));
            checkVal($sformatf("auto_valid%0d", i), 32'(validA), 32'h1);
            if (i < 3) begin
                checkVal($sformatf("nogap_row%0d", i), 32'(rowC), 32'(expRowsC[i]));
                checkVal($sformatf("nogap_idx%0d", i), 32'(idxC), 32'(expIdxC[i]));
                checkVal($sformatf("nogap_valid%0d", i), 32'(validC), 32'h1);
            end
            if (i == 2) checkVal("lfsr_pick1", 32'(dutA.lfsr), 32'h4A);
            if (i == 5) checkVal("lfsr_pick2", 32'(dutA.lfsr), 32'h95);
        end

        // Paused loads are ignored, then the sequence resumes where it left off.
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stepLoad(1'b1);
            checkVal($sformatf("pause_valid%0d", i), 32'(validA), 32'h0);
            checkVal($sformatf("pause_row%0d", i), 32'(rowA), 32'h18);
        end
        pause = 1'b0;
        stepLoad(1'b1);
        checkVal("resume_row0", 32'(rowA), 32'h00);
        stepLoad(1'b1);
        checkVal("resume_row1", 32'(rowA), 32'h00);
        stepLoad(1'b1);
        checkVal("resume_row2", 32'(rowA), 32'h3C);
        checkVal("resume_idx2", 32'(idxA), 32'h2);

        // Reset coinciding with a load wins and restarts the auto sequence.
        rstN = 1'b0;
        stepLoad(1'b0);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepLoad(1'b1);
            checkVal($sformatf("pre_rst_row%0d", i), 32'(rowA), 32'(expRows4[i]));
        end
        rstN = 1'b0;
        stepLoad(1'b1);
        checkVal("rstload_valid", 32'(validA), 32'h0);
        checkVal("rstload_row", 32'(rowA), 32'h00);
        checkVal("rstload_idx", 32'(idxA), 32'h0);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepLoad(1'b1);
            checkVal($sformatf("post_rst_row%0d", i), 32'(rowA), 32'(expRowsA[i]));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
